// File: rtl/reg_file.sv
`default_nettype none
// =============================================================================
// reg_file : 2R1W register file (x0 hardwired to zero, write bypass) with a
//            ready/valid dump port that streams out every register in order.
// Revision : 1.0
// =============================================================================
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] rs1Addr,
   input  logic [ADDR_WIDTH-1:0] rs2Addr,
   output logic [DATA_WIDTH-1:0] rs1Data,
   output logic [DATA_WIDTH-1:0] rs2Data,
   input  logic                  regWrite,
   input  logic [ADDR_WIDTH-1:0] rdAddr,
   input  logic [DATA_WIDTH-1:0] rdData,
   input  logic                  dumpStart,
   output logic                  dumpValid,
   input  logic                  dumpReady,
   output logic [ADDR_WIDTH-1:0] dumpAddr,
   output logic [DATA_WIDTH-1:0] dumpData,
   output logic                  dumpBusy
);

   localparam int                    c_NUM_REGS  = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = {ADDR_WIDTH{1'b1}};
   localparam logic [0:0]            c_IDLE      = 1'b0;
   localparam logic [0:0]            c_SEND      = 1'b1;

   logic [DATA_WIDTH-1:0] regs_q [c_NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [c_NUM_REGS];
   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
   logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  wr_en;

   assign wr_en     = regWrite && (rdAddr != '0);
   assign next_addr = dump_addr_q + ADDR_WIDTH'(1);

   // regs_d is the post-write view, so it doubles as the bypass source
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[rdAddr] = rdData;
      end
      regs_d[0] = '0;
   end

   always_comb begin
      rs1Data = regs_d[rs1Addr];
      rs2Data = regs_d[rs2Addr];
   end

   always_comb begin
      state_d     = state_q;
      dump_addr_d = dump_addr_q;
      dump_data_d = dump_data_q;
      case (state_q)
         c_IDLE: begin
            if (dumpStart) begin
               state_d     = c_SEND;
               dump_addr_d = '0;
               dump_data_d = '0;
            end
         end
         c_SEND: begin
            if (dumpReady) begin
               if (dump_addr_q == c_LAST_ADDR) begin
                  state_d = c_IDLE;
               end else begin
                  dump_addr_d = next_addr;
                  dump_data_d = regs_d[next_addr];
               end
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs_q      <= '{default: '0};
         state_q     <= c_IDLE;
         dump_addr_q <= '0;
         dump_data_q <= '0;
      end else begin
         regs_q      <= regs_d;
         state_q     <= state_d;
         dump_addr_q <= dump_addr_d;
         dump_data_q <= dump_data_d;
      end
   end

   assign dumpValid = (state_q == c_SEND);
   assign dumpBusy  = (state_q != c_IDLE);
   assign dumpAddr  = dump_addr_q;
   assign dumpData  = dump_data_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// tb_reg_file : scoreboard bench for reg_file; dump beats are checked against
// expectations queued when each dump is launched.
module tb_reg_file;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic [4:0]  rs1Addr   = '0;
   logic [4:0]  rs2Addr   = '0;
   logic [31:0] rs1Data;
   logic [31:0] rs2Data;
   logic        regWrite  = 1'b0;
   logic [4:0]  rdAddr    = '0;
   logic [31:0] rdData    = '0;
   logic        dumpStart = 1'b0;
   logic        dumpValid;
   logic        dumpReady = 1'b0;
   logic [4:0]  dumpAddr;
   logic [31:0] dumpData;
   logic        dumpBusy;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } beat_t;

   beat_t       sb [$];
   logic [31:0] model [32];
   int          n_cmp = 0;
   int          n_bad = 0;

   reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .rs1Addr   (rs1Addr),
      .rs2Addr   (rs2Addr),
      .rs1Data   (rs1Data),
      .rs2Data   (rs2Data),
      .regWrite  (regWrite),
      .rdAddr    (rdAddr),
      .rdData    (rdData),
      .dumpStart (dumpStart),
      .dumpValid (dumpValid),
      .dumpReady (dumpReady),
      .dumpAddr  (dumpAddr),
      .dumpData  (dumpData),
      .dumpBusy  (dumpBusy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      regWrite = 1'b1;
      rdAddr   = 5'(a);
      rdData   = d;
      tick();
      regWrite = 1'b0;
      if (a != 0) model[a] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (dumpValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", dumpValid); end
      n_cmp++; if (dumpBusy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", dumpBusy); end
      n_cmp++; if (dumpAddr !== 5'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", dumpAddr); end
      n_cmp++; if (dumpData !== 32'd0) begin n_bad++; $display("FAIL rst_data: got %h want 0", dumpData); end
      for (int i = 0; i < 32; i += 7) begin
         rs1Addr = 5'(i);
         rs2Addr = 5'(31 - i);
         #1;
         n_cmp++; if (rs1Data !== 32'd0) begin n_bad++; $display("FAIL rst_rd1 x%0d: got %h want 0", i, rs1Data); end
         n_cmp++; if (rs2Data !== 32'd0) begin n_bad++; $display("FAIL rst_rd2 x%0d: got %h want 0", 31 - i, rs2Data); end
      end
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   task automatic test_write_read();
      wr(5, 32'hDEADBEEF);
      rs1Addr = 5'd5;
      #1;
      n_cmp++; if (rs1Data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_x5: got %h want deadbeef", rs1Data); end
      wr(0, 32'h1234);
      rs2Addr = 5'd0;
      #1;
      n_cmp++; if (rs2Data !== 32'd0) begin n_bad++; $display("FAIL wr_x0: got %h want 0", rs2Data); end
      // a pending write to x0 must not leak through the bypass
      regWrite = 1'b1; rdAddr = 5'd0; rdData = 32'hFFFFFFFF; rs1Addr = 5'd0;
      #1;
      n_cmp++; if (rs1Data !== 32'd0) begin n_bad++; $display("FAIL byp_x0: got %h want 0", rs1Data); end
      regWrite = 1'b0;
      wr(12, 32'h0BADF00D);
      rs1Addr = 5'd12; rs2Addr = 5'd5;
      #1;
      n_cmp++; if (rs1Data !== 32'h0BADF00D) begin n_bad++; $display("FAIL wr_x12: got %h want 0badf00d", rs1Data); end
      n_cmp++; if (rs2Data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL keep_x5: got %h want deadbeef", rs2Data); end
   endtask

   task automatic test_bypass();
      regWrite = 1'b1; rdAddr = 5'd7; rdData = 32'hA5A5A5A5; rs1Addr = 5'd7; rs2Addr = 5'd7;
      #1;
      n_cmp++; if (rs1Data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL byp_rs1: got %h want a5a5a5a5", rs1Data); end
      n_cmp++; if (rs2Data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL byp_rs2: got %h want a5a5a5a5", rs2Data); end
      rs2Addr = 5'd5;
      #1;
      n_cmp++; if (rs2Data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL byp_other: got %h want deadbeef", rs2Data); end
      tick();
      regWrite = 1'b0;
      model[7] = 32'hA5A5A5A5;
      rs1Addr = 5'd7;
      #1;
      n_cmp++; if (rs1Data !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL byp_stored: got %h want a5a5a5a5", rs1Data); end
   endtask

   task automatic test_dump();
      beat_t e;
      int beats = 0;
      int cyc = 0;
      for (int i = 1; i < 32; i++) wr(i, 32'(i * 3));
      for (int i = 0; i < 32; i++) sb.push_back('{5'(i), model[i]});
      dumpReady = 1'b1; dumpStart = 1'b1;
      tick();
      dumpStart = 1'b0;
      @(negedge clk);
      n_cmp++; if (dumpValid !== 1'b1) begin n_bad++; $display("FAIL dump_first_valid: got %b want 1", dumpValid); end
      while (beats < 32 && cyc < 40) begin
         if (dumpValid === 1'b1) begin
            e = sb.pop_front();
            n_cmp++;
            if (dumpAddr !== e.a || dumpData !== e.d) begin
               n_bad++; $display("FAIL dump_beat: got x%0d=%h want x%0d=%h", dumpAddr, dumpData, e.a, e.d);
            end
            beats++;
         end
         tick();
         @(negedge clk);
         cyc++;
      end
      n_cmp++; if (beats !== 32 || cyc !== 32) begin n_bad++; $display("FAIL dump_count: got %0d beats in %0d cycles want 32 in 32", beats, cyc); end
      n_cmp++; if (dumpBusy !== 1'b0) begin n_bad++; $display("FAIL dump_busy_end: got %b want 0", dumpBusy); end
      sb.delete();
   endtask

   task automatic test_backpressure();
      beat_t e;
      int beats = 0;
      int cyc = 0;
      int stalls = 0;
      for (int i = 0; i < 32; i++) sb.push_back('{5'(i), (i == 5) ? 32'h55555555 : model[i]});
      dumpReady = 1'b1; dumpStart = 1'b1;
      tick();
      dumpStart = 1'b0;
      @(negedge clk);
      while (beats < 32 && cyc < 60) begin
         if (dumpValid === 1'b1 && dumpReady === 1'b0) begin
            n_cmp++;
            if (dumpAddr !== 5'd4 || dumpData !== 32'd12) begin
               n_bad++; $display("FAIL bp_hold: got x%0d=%h want x4=0000000c", dumpAddr, dumpData);
            end
            stalls++;
         end else if (dumpValid === 1'b1) begin
            e = sb.pop_front();
            n_cmp++;
            if (dumpAddr !== e.a || dumpData !== e.d) begin
               n_bad++; $display("FAIL bp_beat: got x%0d=%h want x%0d=%h", dumpAddr, dumpData, e.a, e.d);
            end
            beats++;
         end
         tick();
         regWrite  = 1'b0;
         dumpReady = !(dumpValid === 1'b1 && dumpAddr === 5'd4 && stalls < 5);
         if (!dumpReady && stalls == 0) begin regWrite = 1'b1; rdAddr = 5'd4; rdData = 32'hFFFF; end
         if (!dumpReady && stalls == 1) begin regWrite = 1'b1; rdAddr = 5'd5; rdData = 32'h55555555; end
         @(negedge clk);
         cyc++;
      end
      dumpReady = 1'b1;
      model[4] = 32'hFFFF;
      model[5] = 32'h55555555;
      n_cmp++; if (stalls !== 5 || beats !== 32 || cyc !== 37) begin n_bad++; $display("FAIL bp_count: got %0d stalls %0d beats %0d cycles want 5/32/37", stalls, beats, cyc); end
      rs1Addr = 5'd4;
      #1;
      n_cmp++; if (rs1Data !== 32'hFFFF) begin n_bad++; $display("FAIL bp_x4_written: got %h want 0000ffff", rs1Data); end
      sb.delete();
   endtask

   task automatic test_reset_mid_dump();
      int beats = 0;
      int cyc = 0;
      dumpReady = 1'b1; dumpStart = 1'b1;
      tick();
      dumpStart = 1'b0;
      @(negedge clk);
      while (beats < 11 && cyc < 20) begin
         if (dumpValid === 1'b1) begin
            n_cmp++; if (dumpAddr !== 5'(beats)) begin n_bad++; $display("FAIL rm_addr: got %0d want %0d", dumpAddr, beats); end
            beats++;
         end
         if (beats < 11) begin
            tick();
            @(negedge clk);
         end
         cyc++;
      end
      n_cmp++; if (beats !== 11) begin n_bad++; $display("FAIL rm_beats: got %0d want 11", beats); end
      tick();
      // reset collides with a write and a start request: reset must win
      rst = 1'b1; regWrite = 1'b1; rdAddr = 5'd9; rdData = 32'hDEAD0009; dumpStart = 1'b1;
      tick();
      rst = 1'b0; regWrite = 1'b0; dumpStart = 1'b0;
      @(negedge clk);
      n_cmp++; if (dumpValid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", dumpValid); end
      n_cmp++; if (dumpBusy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", dumpBusy); end
      n_cmp++; if (dumpAddr !== 5'd0 || dumpData !== 32'd0) begin n_bad++; $display("FAIL rm_dump_regs: got x%0d=%h want x0=0", dumpAddr, dumpData); end
      for (int i = 0; i < 32; i++) model[i] = '0;
      for (int i = 1; i < 32; i += 4) begin
         rs1Addr = 5'(i);
         rs2Addr = 5'(i + 2);
         #1;
         n_cmp++; if (rs1Data !== 32'd0 || rs2Data !== 32'd0) begin n_bad++; $display("FAIL rm_read x%0d/x%0d: got %h/%h want 0/0", i, i + 2, rs1Data, rs2Data); end
      end
      for (int k = 0; k < 5; k++) begin
         tick();
         @(negedge clk);
         n_cmp++; if (dumpValid !== 1'b0) begin n_bad++; $display("FAIL rm_no_beats: got %b want 0", dumpValid); end
      end
   endtask

   task automatic test_start_during_send();
      beat_t e;
      int beats = 0;
      int cyc = 0;
      for (int i = 1; i < 32; i++) wr(i, 32'hC0DE0000 | 32'(i));
      for (int i = 0; i < 32; i++) sb.push_back('{5'(i), (i == 10) ? 32'h0000BEEF : model[i]});
      dumpReady = 1'b1; dumpStart = 1'b1;
      tick();
      dumpStart = 1'b0;
      @(negedge clk);
      while (cyc < 45) begin
         if (dumpValid === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++; $display("FAIL sd_extra: got beat x%0d want none", dumpAddr);
            end else begin
               e = sb.pop_front();
               n_cmp++;
               if (dumpAddr !== e.a || dumpData !== e.d) begin
                  n_bad++; $display("FAIL sd_beat: got x%0d=%h want x%0d=%h", dumpAddr, dumpData, e.a, e.d);
               end
            end
            beats++;
         end
         tick();
         regWrite  = 1'b0;
         dumpStart = 1'b0;
         if (cyc == 5) dumpStart = 1'b1;
         if (dumpValid === 1'b1 && dumpAddr === 5'd31) dumpStart = 1'b1;
         // write x10 on the very edge that advances the dump onto x10
         if (dumpValid === 1'b1 && dumpAddr === 5'd9) begin regWrite = 1'b1; rdAddr = 5'd10; rdData = 32'h0000BEEF; end
         @(negedge clk);
         cyc++;
      end
      model[10] = 32'h0000BEEF;
      n_cmp++; if (beats !== 32) begin n_bad++; $display("FAIL sd_count: got %0d want 32", beats); end
      n_cmp++; if (dumpBusy !== 1'b0) begin n_bad++; $display("FAIL sd_busy_end: got %b want 0", dumpBusy); end
      rs1Addr = 5'd10;
      #1;
      n_cmp++; if (rs1Data !== 32'h0000BEEF) begin n_bad++; $display("FAIL sd_x10: got %h want 0000beef", rs1Data); end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bypass();
      test_dump();
      test_backpressure();
      test_reset_mid_dump();
      test_start_during_send();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
